// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: block geometry, message type and FSM states.
package sha256_pkg;

  localparam int BLOCK_W             = 512;
  localparam int NIBBLES             = 128;
  localparam int LEN_FIELD_W         = 64;
  localparam int SINGLE_BLK_MAX_BITS = 444;
  localparam int MSG_MAX_BITS        = 512;

  typedef logic [NIBBLES-1:0][3:0] nibble_msg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BLK0 = 2'd1,
    BLK1 = 2'd2
  } pad_state_t;

  // Marker plus 64-bit length no longer fit behind the message in one block.
  function automatic logic needs_two_blocks(input logic [9:0] len_bits);
    return (len_bits > 10'(SINGLE_BLK_MAX_BITS));
  endfunction

endpackage

// File: rtl/sha256_pad_block_builder.sv
// Combinational builder of one padded 512-bit block from (message, bit length, block index).
module sha256_pad_block_builder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  nibble_msg_t          msg,
  input  logic [9:0]           len_bits,
  input  logic                 blk_idx,
  output logic [BLOCK_W-1:0]   block
);

  logic [7:0]         nib_len_s;
  logic [BLOCK_W-1:0] body_s;
  logic               is_final_s;

  assign nib_len_s  = len_bits[9:2];
  assign is_final_s = blk_idx | ~needs_two_blocks(len_bits);

  // Global nibble index is {blk_idx, j}; message below the marker, zeros after it.
  always_comb begin
    body_s = '0;
    for (int j = 0; j < NIBBLES; j++) begin
      if ({blk_idx, 7'(j)} < nib_len_s) begin
        body_s[BLOCK_W-1-4*j -: 4] = msg[j];
      end else if ({blk_idx, 7'(j)} == nib_len_s) begin
        body_s[BLOCK_W-1-4*j -: 4] = 4'h8;
      end else begin
        body_s[BLOCK_W-1-4*j -: 4] = 4'h0;
      end
    end
  end

  assign block = is_final_s ? {body_s[BLOCK_W-1:LEN_W], LEN_W'(len_bits)} : body_s;

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: accepts (mess, size) and streams one or two padded blocks.
// Optional size checking is enabled by defining SHA256_PAD_SIZE_CHECK_EN.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int MAX_NIBBLES = 128,
  parameter int LEN_FIELD_W = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MAX_NIBBLES-1:0][3:0] mess,
  input  logic [31:0]                 size,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BLOCK_W-1:0]          out_block,
  output logic                        out_first,
  output logic                        out_last,
  output logic                        size_err
);

  pad_state_t         state_q, state_d;
  nibble_msg_t        msg_q, msg_d;
  logic [9:0]         len_q, len_d;
  logic               out_valid_q, out_valid_d;
  logic               out_first_q, out_first_d;
  logic               out_last_q, out_last_d;
  logic [BLOCK_W-1:0] out_block_q, out_block_d;
  logic               size_err_q, size_err_d;

  logic [9:0]         in_len_s;
  logic               size_over_s;
  logic               size_bad_s;
  nibble_msg_t        bld_msg_s;
  logic [9:0]         bld_len_s;
  logic               bld_idx_s;
  logic [BLOCK_W-1:0] bld_block_s;

  assign size_over_s = (|size[31:10]) | (size[9:0] > 10'd512);

  always_comb begin
    if (size_over_s) begin
      in_len_s = 10'd512;
    end else begin
      in_len_s = {size[9:2], 2'b00};
    end
  end

`ifdef SHA256_PAD_SIZE_CHECK_EN
  assign size_bad_s = size_over_s | (size[1:0] != 2'b00);
`else
  assign size_bad_s = 1'b0;
`endif

  // In IDLE the builder sees the incoming message so block 0 is ready one cycle after accept.
  always_comb begin
    bld_msg_s = msg_q;
    bld_len_s = len_q;
    bld_idx_s = 1'b1;
    if (state_q == IDLE) begin
      bld_msg_s = mess;
      bld_len_s = in_len_s;
      bld_idx_s = 1'b0;
    end else begin
      bld_msg_s = msg_q;
      bld_len_s = len_q;
      bld_idx_s = 1'b1;
    end
  end

  sha256_pad_block_builder #(.LEN_W(LEN_FIELD_W)) u_builder (
    .msg      (bld_msg_s),
    .len_bits (bld_len_s),
    .blk_idx  (bld_idx_s),
    .block    (bld_block_s)
  );

  always_comb begin
    state_d     = state_q;
    msg_d       = msg_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_block_d = out_block_q;
    size_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && size_bad_s) begin
          size_err_d = 1'b1;
        end else if (in_valid) begin
          msg_d       = mess;
          len_d       = in_len_s;
          out_valid_d = 1'b1;
          out_first_d = 1'b1;
          out_last_d  = ~needs_two_blocks(in_len_s);
          out_block_d = bld_block_s;
          state_d     = BLK0;
        end else begin
          state_d = IDLE;
        end
      end
      BLK0: begin
        if (out_ready && needs_two_blocks(len_q)) begin
          out_first_d = 1'b0;
          out_last_d  = 1'b1;
          out_block_d = bld_block_s;
          state_d     = BLK1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_first_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = BLK0;
        end
      end
      BLK1: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_first_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = BLK1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any latched message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      msg_q       <= '0;
      len_q       <= 10'd0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_block_q <= '0;
      size_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_block_q <= out_block_d;
      size_err_q  <= size_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_block = out_block_q;
  assign size_err  = size_err_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: driver queues hand-computed blocks, monitor checks them.
module tb_sha256_msg_padder;

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [127:0][3:0] mess = '0;
  logic [31:0]       size = 32'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [511:0]      out_block;
  logic              out_first;
  logic              out_last;
  logic              size_err;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  sha256_msg_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mess      (mess),
    .size      (size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last),
    .size_err  (size_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output block is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block actual=%0h required=none", out_block);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("block", out_block, e.blk);
        chk("first", {511'd0, out_first}, {511'd0, e.first});
        chk("last", {511'd0, out_last}, {511'd0, e.last});
      end
    end
`ifndef SHA256_PAD_SIZE_CHECK_EN
    if (rst_n && size_err) begin
      checks++;
      errors++;
      $display("FAIL size_err_tied actual=1 required=0");
    end
`endif
  end

  task automatic push(input logic [511:0] b, input logic f, input logic l);
    exp_t e;
    e.blk = b; e.first = f; e.last = l;
    q.push_back(e);
  endtask

  task automatic send(input logic [127:0][3:0] m, input logic [31:0] s);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    mess = m; size = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {511'd0, in_ready}, {511'd0, 1'b1});
    chk({name, "_drained"}, 512'(q.size()), 512'd0);
  endtask

  logic [127:0][3:0] m_abc, m_f, m_a, m_seq;
  logic [511:0]      b512_0, b512_1;

  initial begin
    for (int i = 0; i < 128; i++) begin
      m_abc[i] = 4'h5;
      m_f[i]   = 4'hF;
      m_a[i]   = 4'hA;
      m_seq[i] = 4'(i);
    end
    m_abc[0] = 4'h6; m_abc[1] = 4'h1; m_abc[2] = 4'h6;
    m_abc[3] = 4'h2; m_abc[4] = 4'h6; m_abc[5] = 4'h3;
    b512_0 = {8{64'h0123456789ABCDEF}};
    b512_1 = {4'h8, 444'd0, 64'h200};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_out_block", out_block, 512'd0);
    chk("rst_flags", {509'd0, out_first, out_last, size_err}, 512'd0);
    chk("rst_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Empty message
    push({4'h8, 508'd0}, 1'b1, 1'b1);
    send('0, 32'd0);
    drain("t1_idle");

    // "abc" with garbage beyond the message that must be masked
    push({32'h61626380, 416'd0, 64'h18}, 1'b1, 1'b1);
    send(m_abc, 32'd24);
    drain("t2_idle");

    // 444 bits: still a single block
    push({{111{4'hF}}, 4'h8, 64'h1BC}, 1'b1, 1'b1);
    send(m_f, 32'd444);
    drain("t3_idle");

    // 448 bits: two blocks
    push({{112{4'hA}}, 4'h8, 60'd0}, 1'b1, 1'b0);
    push({448'd0, 64'h1C0}, 1'b0, 1'b1);
    send(m_a, 32'd448);
    drain("t4_idle");

    // 512 bits with backpressure on block 0
    out_ready = 1'b0;
    push(b512_0, 1'b1, 1'b0);
    push(b512_1, 1'b0, 1'b1);
    send(m_seq, 32'd512);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {511'd0, out_valid}, {511'd0, 1'b1});
      chk("bp_block", out_block, b512_0);
      chk("bp_in_ready", {511'd0, in_ready}, 512'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("t5_idle");

    // Reset while in BLK1
    out_ready = 1'b0;
    push({{112{4'hA}}, 4'h8, 60'd0}, 1'b1, 1'b0);
    send(m_a, 32'd448);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("blk1_valid", {511'd0, out_valid}, {511'd0, 1'b1});
    chk("blk1_flags", {510'd0, out_first, out_last}, {510'd0, 2'b01});
    chk("blk1_block", out_block, {448'd0, 64'h1C0});
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("arst_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});
    chk("arst_queue", 512'(q.size()), 512'd0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("post_rst_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});

    push({4'h8, 508'd0}, 1'b1, 1'b1);
    send('0, 32'd0);
    drain("t6_idle");

`ifdef SHA256_PAD_SIZE_CHECK_EN
    send(m_seq, 32'd516);
    @(negedge clk);
    chk("size_err_pulse", {511'd0, size_err}, {511'd0, 1'b1});
    chk("size_err_no_valid", {511'd0, out_valid}, 512'd0);
    @(negedge clk);
    chk("size_err_drop", {511'd0, size_err}, 512'd0);
    chk("size_err_idle", {511'd0, in_ready}, {511'd0, 1'b1});
    send(m_abc, 32'd26);
    @(negedge clk);
    chk("size_err_align", {511'd0, size_err}, {511'd0, 1'b1});
    repeat (3) @(negedge clk);
    chk("size_err_align_no_valid", {511'd0, out_valid}, 512'd0);
`else
    // Oversize clamps to 512, misaligned size truncates to 24
    push(b512_0, 1'b1, 1'b0);
    push(b512_1, 1'b0, 1'b1);
    send(m_seq, 32'd516);
    drain("clamp_idle");
    push({32'h61626380, 416'd0, 64'h18}, 1'b1, 1'b1);
    send(m_abc, 32'd26);
    drain("trunc_idle");
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
